// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with overlap/non-overlap modes,
// a saturating match counter and a history fill level.
module seq_detect_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8,
  localparam int                FILL_W  = $clog2(PAT_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              x,
  input  logic              en,
  input  logic              overlap,
  input  logic              clear,
  output logic              match,
  output logic [CNT_W-1:0]  count,
  output logic              sat,
  output logic [FILL_W-1:0] fill
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_LEN-1:0] hist_q, hist_d, hist_n;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_n;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               match_q, match_d;
  logic               hit;

  always_comb begin
    hist_n  = {hist_q[PAT_LEN-2:0], x};
    fill_n  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    // Hits need a full window of fresh bits, so reset zeros never match.
    hit     = en && !clear && (fill_n == FILL_FULL) && (hist_n == PATTERN);
    hist_d  = hist_q;
    fill_d  = fill_q;
    count_d = count_q;
    match_d = 1'b0;
    if (clear) begin
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (en) begin
      hist_d  = hist_n;
      fill_d  = (hit && !overlap) ? '0 : fill_n;
      match_d = hit;
      if (hit && (count_q != CNT_MAX)) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;
  assign count = count_q;
  assign fill  = fill_q;
  assign sat   = (count_q == CNT_MAX);

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 4, giving the pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter PATTERN, default 4'b1011, PAT_LEN bits wide; the MSB is the first bit received.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the match-counter width (legal range 2..32).
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port x, input, 1 bit: serial data bit, sampled at a clk edge only when en=1.
REQ-007 Port en, input, 1 bit: sample enable.
REQ-008 Port overlap, input, 1 bit: mode select; 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-009 Port clear, input, 1 bit: synchronous soft clear.
REQ-010 Port match, output, 1 bit: registered one-cycle match pulse.
REQ-011 Port count, output, CNT_W bits: saturating count of matches.
REQ-012 Port sat, output, 1 bit: high while count equals 2^CNT_W-1.
REQ-013 Port fill, output, clog2(PAT_LEN+1) bits: number of valid history bits, 0..PAT_LEN.

Function
REQ-014 The block SHALL hold a PAT_LEN-bit history register hist and the fill counter fill.
REQ-015 On an edge with en=1 and clear=0, the block SHALL form hist_n = {hist[PAT_LEN-2:0], x}.
REQ-016 On the same edge, it SHALL form fill_n = min(fill+1, PAT_LEN).
REQ-017 A hit SHALL occur when en=1, clear=0, fill_n==PAT_LEN and hist_n==PATTERN.
REQ-018 hist SHALL load hist_n.
REQ-019 fill SHALL load fill_n, except on a hit with overlap=0, where fill SHALL load 0.
REQ-020 On a hit with overlap=1, fill SHALL remain PAT_LEN, so the trailing bits can start the next match.
REQ-021 overlap SHALL be sampled on the same edge as x; a mode change takes effect for that sample.
REQ-022 match SHALL be 1 for exactly the cycle after a hit edge, else 0; latency is one clock from the edge sampling the last pattern bit.
REQ-023 On each hit, count SHALL increment by 1 if below 2^CNT_W-1, else hold (no wrap).
REQ-024 sat SHALL be the combinational decode count==2^CNT_W-1.
REQ-025 With en=0 and clear=0, hist, fill and count SHALL hold, and match SHALL be 0 after the edge.
REQ-026 With clear=1 at an edge, hist, fill, count and match SHALL all go to 0, regardless of en and x.
REQ-027 clear SHALL take priority over a simultaneous hit, and that hit SHALL NOT be counted.
REQ-028 Consecutive hits (overlap=1) SHALL produce match high on consecutive cycles, with count +1 per cycle.

Reset
REQ-029 While rst=1, asynchronously and independent of clk: hist=0, fill=0, count=0, match=0, sat=0.
REQ-030 On rst deassertion, the first en=1 edge SHALL be treated as pattern bit 1.
REQ-031 rst asserted mid-pattern SHALL discard partial history; no match SHALL be reported for bits received before rst.
REQ-032 While fill<PAT_LEN, the block SHALL never report a hit, so reset-state zeros can never cause a false match (e.g. PATTERN=4'b0000).

Verification (PAT_LEN=4, PATTERN=1011, CNT_W=8 unless stated)
REQ-033 Bench SHALL check overlap: overlap=1, en=1, x=1,0,1,1,0,1,1 -> match after bit 4 and bit 7; count=2; fill=4 at end.
REQ-034 Bench SHALL check non-overlap: same stream with overlap=0 -> match after bit 4 only; count=1; fill=3 at end.
REQ-035 Bench SHALL check enable gaps: x=1,0 with en=1, then 3 cycles en=0 with x toggling, then x=1,1 with en=1 -> single match after the last bit; fill unchanged during gap.
REQ-036 Bench SHALL check clear vs hit: clear=1 on the edge sampling the 4th bit of 1011 -> match stays 0; count=0; fill=0.
REQ-037 Bench SHALL check saturation: CNT_W=2, overlap=1, x stream 1011011011011011 (5 overlapping hits) -> count reaches 3 after the 3rd hit and holds; sat=1; match still pulses on the 4th and 5th hits.
REQ-038 Bench SHALL check async reset: rst pulsed between clk edges after x=1,0,1 -> outputs 0 immediately; then x=1 -> no match; then full 1,0,1,1 -> match.
